// File: rtl/pc_pkg.sv
// Shared types for the program-counter / fetch sequencer.
package pc_pkg;

  // Default program-counter and LUT target width.
  localparam int PC_W = 10;

  // Top-level sequencing states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

  // Source of the next program counter.
  typedef enum logic [1:0] {
    NPC_HOLD = 2'd0,
    NPC_INC  = 2'd1,
    NPC_ABS  = 2'd2,
    NPC_REL  = 2'd3
  } npc_sel_t;

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC arithmetic: hold, increment, absolute load or signed-relative add.
// All sums are truncated to D bits, giving modulo-2^D wrap.
module pc_next_calc
  import pc_pkg::*;
#(
  parameter int D = PC_W
) (
  input  logic [D-1:0] prog_ctr,
  input  logic [D-1:0] lut_target,
  input  npc_sel_t     sel,
  output logic [D-1:0] next_pc
);

  localparam logic [D-1:0] ONE = {{(D-1){1'b0}}, 1'b1};

  // Select the next PC; a relative offset is two's complement, so a plain
  // D-bit add already implements the signed displacement.
  always_comb begin
    next_pc = prog_ctr;
    case (sel)
      NPC_HOLD: next_pc = prog_ctr;
      NPC_INC:  next_pc = prog_ctr + ONE;
      NPC_ABS:  next_pc = lut_target;
      NPC_REL:  next_pc = prog_ctr + lut_target;
      default:  next_pc = prog_ctr;
    endcase
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program-counter and fetch sequencer. Drives the branch-target LUT index,
// consumes the LUT target in the same cycle and registers the next PC.
module pc_fetch_ctrl
  import pc_pkg::*;
#(
  parameter int D  = PC_W,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stall,
  input  logic          halt_req,
  input  logic          branch_en,
  input  logic          branch_taken,
  input  logic          jump_abs,
  input  logic [3:0]    lut_idx,
  output logic [3:0]    lut_addr,
  input  logic [D-1:0]  lut_target,
  output logic [D-1:0]  prog_ctr,
  output logic          running,
  output logic          done,
  output logic [CW-1:0] instr_count
);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  fetch_state_t  state;
  fetch_state_t  next_state;
  npc_sel_t      pc_sel;
  logic          clear;
  logic          cnt_inc;
  logic [D-1:0]  next_pc;

  // The LUT is read combinationally so target and decision resolve together.
  assign lut_addr = lut_idx;

  pc_next_calc #(.D(D)) u_next (
    .prog_ctr   (prog_ctr),
    .lut_target (lut_target),
    .sel        (pc_sel),
    .next_pc    (next_pc)
  );

  // Next-state and datapath control; stall beats halt, halt beats branch.
  always_comb begin
    next_state = state;
    pc_sel     = NPC_HOLD;
    clear      = 1'b0;
    cnt_inc    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = RUN;
          clear      = 1'b1;
        end else begin
          next_state = IDLE;
        end
      end
      RUN: begin
        if (stall) begin
          pc_sel = NPC_HOLD;
        end else if (halt_req) begin
          next_state = DONE;
          pc_sel     = NPC_HOLD;
          cnt_inc    = 1'b1;
        end else if (branch_en && branch_taken) begin
          pc_sel  = jump_abs ? NPC_ABS : NPC_REL;
          cnt_inc = 1'b1;
        end else begin
          pc_sel  = NPC_INC;
          cnt_inc = 1'b1;
        end
      end
      DONE: begin
        if (start) begin
          next_state = RUN;
          clear      = 1'b1;
        end else begin
          next_state = DONE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State, PC, retire counter and status flags; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      prog_ctr    <= {D{1'b0}};
      instr_count <= {CW{1'b0}};
      running     <= 1'b0;
      done        <= 1'b0;
    end else begin
      state   <= next_state;
      running <= (next_state == RUN);
      done    <= (next_state == DONE);
      if (clear) begin
        prog_ctr    <= {D{1'b0}};
        instr_count <= {CW{1'b0}};
      end else begin
        prog_ctr <= next_pc;
        if (cnt_inc && (instr_count != CNT_MAX)) begin
          instr_count <= instr_count + CNT_ONE;
        end else begin
          instr_count <= instr_count;
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios plus randomized
// traffic, all checked against an integer-arithmetic reference model.
module tb_pc_fetch_ctrl;

  localparam int D   = 10;
  localparam int CW  = 6;
  localparam int MOD = 1 << D;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset, start, stall, halt_req, branch_en, branch_taken, jump_abs;
  logic [3:0]    lut_idx, lut_addr;
  logic [D-1:0]  lut_target, prog_ctr;
  logic          running, done;
  logic [CW-1:0] instr_count;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: mode 0 = idle, 1 = run, 2 = done.
  int m_mode, m_pc, m_cnt;

  pc_fetch_ctrl #(.D(D), .CW(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .halt_req(halt_req), .branch_en(branch_en), .branch_taken(branch_taken),
    .jump_abs(jump_abs), .lut_idx(lut_idx), .lut_addr(lut_addr),
    .lut_target(lut_target), .prog_ctr(prog_ctr), .running(running),
    .done(done), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  function automatic logic [CW+D+1:0] exp_vec();
    return {(m_mode == 1), (m_mode == 2), CW'(m_cnt), D'(m_pc)};
  endfunction

  function automatic logic [CW+D+1:0] act_vec();
    return {running, done, instr_count, prog_ctr};
  endfunction

  // Advance one clock: evaluate the model on the pre-edge inputs, then
  // commit after the edge so outputs are observed 1 time unit later.
  task automatic step();
    int n_mode, n_pc, n_cnt, off;
    n_mode = m_mode; n_pc = m_pc; n_cnt = m_cnt;
    if (reset) begin
      n_mode = 0; n_pc = 0; n_cnt = 0;
    end else if (m_mode != 1) begin
      if (start) begin
        n_mode = 1; n_pc = 0; n_cnt = 0;
      end
    end else if (!stall) begin
      n_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
      if (halt_req) begin
        n_mode = 2;
      end else if (branch_en && branch_taken) begin
        off  = (int'(lut_target) >= MOD / 2) ? int'(lut_target) - MOD : int'(lut_target);
        n_pc = jump_abs ? int'(lut_target) : (m_pc + off + MOD) % MOD;
      end else begin
        n_pc = (m_pc + 1) % MOD;
      end
    end
    @(posedge clk);
    #1;
    m_mode = n_mode; m_pc = n_pc; m_cnt = n_cnt;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; start = 1'b0; stall = 1'b0; halt_req = 1'b0;
    branch_en = 1'b0; branch_taken = 1'b0; jump_abs = 1'b0;
    lut_idx = 4'd0; lut_target = '0;
  endtask

  task automatic do_reset_start();
    idle_inputs(); reset = 1'b1; step();
    reset = 1'b0; start = 1'b1; step();
    start = 1'b0;
  endtask

  task automatic goto_pc(input int t);
    branch_en = 1'b1; branch_taken = 1'b1; jump_abs = 1'b1; lut_target = D'(t);
    step();
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs(); reset = 1'b1;
    m_mode = 0; m_pc = 0; m_cnt = 0;
    step(); step();
    reset = 1'b0;
    vectors++;
    if (act_vec() !== '0) begin
      miscompares++; $display("FAIL reset_state got %h exp 0", act_vec());
    end
  endtask

  task automatic test_sequential();
    do_reset_start();
    vectors++;
    if (prog_ctr !== 10'd0 || running !== 1'b1 || instr_count !== 6'd0) begin
      miscompares++; $display("FAIL start pc=%0d run=%0b cnt=%0d exp 0/1/0", prog_ctr, running, instr_count);
    end
    for (int i = 1; i <= 5; i++) begin
      step();
      vectors++;
      if (prog_ctr !== D'(i)) begin
        miscompares++; $display("FAIL seq_pc got %0d exp %0d", prog_ctr, i);
      end
    end
    vectors++;
    if (instr_count !== 6'd5 || running !== 1'b1 || act_vec() !== exp_vec()) begin
      miscompares++; $display("FAIL seq_count got %0d exp 5", instr_count);
    end
  endtask

  task automatic test_relative();
    goto_pc(4);
    branch_en = 1'b1; branch_taken = 1'b1; jump_abs = 1'b0; lut_target = 10'h3FF;
    step(); idle_inputs();
    vectors++;
    if (prog_ctr !== 10'd3) begin
      miscompares++; $display("FAIL rel_minus1 got %0d exp 3", prog_ctr);
    end
    goto_pc(20);
    branch_en = 1'b1; branch_taken = 1'b1; jump_abs = 1'b0; lut_target = 10'h3FB;
    step(); idle_inputs();
    vectors++;
    if (prog_ctr !== 10'd15 || act_vec() !== exp_vec()) begin
      miscompares++; $display("FAIL rel_minus5 got %0d exp 15", prog_ctr);
    end
  endtask

  task automatic test_absolute();
    goto_pc(7);
    branch_en = 1'b1; branch_taken = 1'b1; jump_abs = 1'b1;
    lut_idx = 4'd4; lut_target = 10'd113;
    #1;
    vectors++;
    if (lut_addr !== 4'd4) begin
      miscompares++; $display("FAIL lut_addr got %0d exp 4", lut_addr);
    end
    step(); idle_inputs();
    vectors++;
    if (prog_ctr !== 10'd113) begin
      miscompares++; $display("FAIL abs_jump got %0d exp 113", prog_ctr);
    end
    goto_pc(7);
    branch_en = 1'b1; branch_taken = 1'b0; jump_abs = 1'b1;
    lut_idx = 4'd4; lut_target = 10'd113;
    step(); idle_inputs();
    vectors++;
    if (prog_ctr !== 10'd8 || act_vec() !== exp_vec()) begin
      miscompares++; $display("FAIL not_taken got %0d exp 8", prog_ctr);
    end
  endtask

  task automatic test_stall();
    int cnt0;
    goto_pc(12);
    cnt0 = int'(instr_count);
    stall = 1'b1; branch_en = 1'b1; branch_taken = 1'b1; jump_abs = 1'b1;
    lut_target = 10'd200;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (prog_ctr !== 10'd12 || int'(instr_count) != cnt0) begin
        miscompares++; $display("FAIL stall_hold pc=%0d cnt=%0d exp 12/%0d", prog_ctr, instr_count, cnt0);
      end
    end
    stall = 1'b0;
    step(); idle_inputs();
    vectors++;
    if (prog_ctr !== 10'd200 || int'(instr_count) != cnt0 + 1) begin
      miscompares++; $display("FAIL stall_release pc=%0d cnt=%0d exp 200/%0d", prog_ctr, instr_count, cnt0 + 1);
    end
  endtask

  task automatic test_wrap();
    goto_pc(1023);
    step();
    vectors++;
    if (prog_ctr !== 10'd0) begin
      miscompares++; $display("FAIL wrap_inc got %0d exp 0", prog_ctr);
    end
    goto_pc(1022);
    branch_en = 1'b1; branch_taken = 1'b1; jump_abs = 1'b0; lut_target = 10'd2;
    step(); idle_inputs();
    vectors++;
    if (prog_ctr !== 10'd0 || act_vec() !== exp_vec()) begin
      miscompares++; $display("FAIL wrap_rel got %0d exp 0", prog_ctr);
    end
  endtask

  task automatic test_halt_restart();
    int cnt0;
    goto_pc(50);
    cnt0 = int'(instr_count);
    halt_req = 1'b1; branch_en = 1'b1; branch_taken = 1'b1; jump_abs = 1'b1;
    lut_target = 10'd300;
    step(); idle_inputs();
    vectors++;
    if (prog_ctr !== 10'd50 || done !== 1'b1 || running !== 1'b0 || int'(instr_count) != cnt0 + 1) begin
      miscompares++; $display("FAIL halt pc=%0d done=%0b cnt=%0d exp 50/1/%0d", prog_ctr, done, instr_count, cnt0 + 1);
    end
    branch_en = 1'b1; branch_taken = 1'b1; lut_target = 10'd9; halt_req = 1'b1;
    step(); idle_inputs();
    vectors++;
    if (act_vec() !== exp_vec() || prog_ctr !== 10'd50) begin
      miscompares++; $display("FAIL done_hold got %h exp %h", act_vec(), exp_vec());
    end
    start = 1'b1; step(); start = 1'b0;
    vectors++;
    if (prog_ctr !== 10'd0 || instr_count !== 6'd0 || running !== 1'b1 || done !== 1'b0) begin
      miscompares++; $display("FAIL restart pc=%0d cnt=%0d exp 0/0", prog_ctr, instr_count);
    end
    step(); step();
    reset = 1'b1; branch_en = 1'b1; branch_taken = 1'b1; jump_abs = 1'b1; lut_target = 10'd77;
    step(); idle_inputs();
    vectors++;
    if (act_vec() !== '0) begin
      miscompares++; $display("FAIL reset_midrun got %h exp 0", act_vec());
    end
  endtask

  task automatic test_saturate();
    do_reset_start();
    for (int i = 0; i < CMAX + 6; i++) step();
    vectors++;
    if (instr_count !== 6'd63 || act_vec() !== exp_vec()) begin
      miscompares++; $display("FAIL saturate cnt=%0d exp 63", instr_count);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      reset        = ($urandom_range(0, 59) == 0);
      start        = ($urandom_range(0, 7) == 0);
      stall        = ($urandom_range(0, 3) == 0);
      halt_req     = ($urandom_range(0, 24) == 0);
      branch_en    = 1'($urandom_range(0, 1));
      branch_taken = 1'($urandom_range(0, 1));
      jump_abs     = 1'($urandom_range(0, 1));
      lut_idx      = 4'($urandom_range(0, 15));
      lut_target   = D'($urandom_range(0, MOD - 1));
      #1;
      vectors++;
      if (lut_addr !== lut_idx) begin
        miscompares++; $display("FAIL rnd_lut_addr it=%0d got %0d exp %0d", i, lut_addr, lut_idx);
      end
      step();
      vectors++;
      if (act_vec() !== exp_vec()) begin
        miscompares++; $display("FAIL rnd_state it=%0d got %h exp %h", i, act_vec(), exp_vec());
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_sequential();
    test_relative();
    test_absolute();
    test_stall();
    test_wrap();
    test_halt_restart();
    test_saturate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Program-counter and fetch sequencer that sits directly downstream of the branch-target LUT.
- Drives the LUT index, consumes the LUT target, and registers the next program counter each cycle.
- Supports sequential, absolute and relative flow; target is absolute, or a two's-complement offset added modulo 2^D.
- Runs a start/halt/done handshake with the testbench/top level and retires an instruction count.

Parameters:
- D, 10, program counter and LUT target width in bits.
- CW, 16, instruction-retire counter width.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high; clears all state
- start  input  1  begin execution from PC 0 (sampled in IDLE or DONE)
- stall  input  1  hold PC and counter this cycle
- halt_req  input  1  current instruction is the terminating instruction
- branch_en  input  1  current instruction is a branch/jump
- branch_taken  input  1  branch condition true (ignored unless branch_en)
- jump_abs  input  1  1 = absolute target, 0 = relative offset
- lut_idx  input  4  target-table index from decode
- lut_addr  output  4  index driven to the target LUT (combinational copy of lut_idx)
- lut_target  input  D  LUT output, same cycle as lut_addr
- prog_ctr  output  D  current program counter (registered)
- running  output  1  high in RUN
- done  output  1  high in DONE
- instr_count  output  CW  instructions retired since last start

Behaviour:
- Reset: state=IDLE, prog_ctr=0, instr_count=0, running=0, done=0. Reset has priority over every other input in any state, including mid-RUN.
- States: IDLE, RUN, DONE.
  - IDLE -> RUN when start=1. prog_ctr:=0, instr_count:=0.
  - RUN -> DONE when halt_req=1 and stall=0. prog_ctr holds; instr_count increments for the halt instruction.
  - DONE -> RUN when start=1. prog_ctr:=0, instr_count:=0. Otherwise DONE holds with done=1.
- Start: in RUN, start is ignored.
- RUN next-PC priority (one-cycle latency; new value visible the cycle after the sampling edge):
  1. stall=1: prog_ctr and instr_count hold; all other inputs ignored.
  2. halt_req=1: go to DONE; PC holds. Halt wins over a simultaneous branch.
  3. branch_en=1 and branch_taken=1, jump_abs=1: prog_ctr := lut_target.
  4. branch_en=1 and branch_taken=1, jump_abs=0: prog_ctr := (prog_ctr + lut_target) mod 2^D. lut_target is treated as signed D-bit; no overflow flag.
  5. otherwise: prog_ctr := (prog_ctr + 1) mod 2^D. 2^D-1 wraps to 0.
- Branch not taken (branch_en=1, branch_taken=0): behaves as case 5.
- instr_count: increments by 1 on every non-stalled RUN cycle and saturates at 2^CW-1.
- lut_addr = lut_idx in every state. The LUT read is combinational, so target and decision resolve in the same cycle.
- Outside RUN: stall, halt_req and branch inputs have no effect.

Decomposition:
- pc_pkg holds:
  - state enum fetch_state_t {IDLE, RUN, DONE};
  - constant PC_W=10;
  - next-PC select enum {NPC_HOLD, NPC_INC, NPC_ABS, NPC_REL}.
- One sub-module, pc_next_calc: purely combinational. Takes prog_ctr, lut_target and the select, and returns the next PC with modulo-2^D arithmetic.
- The FSM, counter and registers stay in pc_fetch_ctrl.

Test Plan:
- Reset then start pulse, 5 plain cycles -> prog_ctr 0,1,2,3,4,5; running=1; instr_count=5.
- prog_ctr=4, branch taken, relative, lut_target=10'h3FF (-1) -> prog_ctr=3 next cycle. From prog_ctr=20, lut_target=10'h3FB (-5) -> 15.
- prog_ctr=7, branch taken, absolute, lut_idx=4, lut_target=113 -> lut_addr=4, prog_ctr=113. Same with branch_taken=0 -> prog_ctr=8.
- Stall for 3 cycles at prog_ctr=12 with branch asserted -> prog_ctr stays 12 and instr_count unchanged. The branch then applies on the first unstalled cycle.
- prog_ctr=1023, no branch -> prog_ctr=0. Relative +2 from 1022 -> 0.
- halt_req with a simultaneous taken branch at prog_ctr=50 -> DONE, prog_ctr=50, done=1, count+1. Restart with start -> prog_ctr=0, count=0. Reset asserted mid-RUN -> IDLE, all outputs 0 next cycle.
